// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    modport master (input in_valid, in_byte, output in_ready, mem_we, mem_addr, mem_wd);
    modport slave  (output in_valid, in_byte, input in_ready, mem_we, mem_addr, mem_wd);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: assembles a big-endian byte stream into words and writes them to
// instruction memory, holding the core in reset until the load completes.
module imem_loader #(
    parameter int DEPTH = 32,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [CW-1:0] word_count,
    imem_loader_if.master bus,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          cpu_rst_n
);
    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;
    localparam logic [CW-1:0] DEPTH_W = CW'(DEPTH);
    state_t        state;
    logic [CW-1:0] count;
    logic [CW-1:0] word_index;
    logic [1:0]    byte_cnt;
    logic [23:0]   sr;
    logic          count_ok;
    assign count_ok = (word_count != '0) && (word_count <= DEPTH_W);
    // Outputs are registered alongside each transition so they track the state exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            count        <= '0;
            word_index   <= '0;
            byte_cnt     <= '0;
            sr           <= '0;
            bus.in_ready <= 1'b0;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_wd   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            cpu_rst_n    <= 1'b0;
        end else begin
            bus.mem_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start && count_ok) begin
                        count        <= word_count;
                        word_index   <= '0;
                        byte_cnt     <= '0;
                        err          <= 1'b0;
                        done         <= 1'b0;
                        cpu_rst_n    <= 1'b0;
                        busy         <= 1'b1;
                        bus.in_ready <= 1'b1;
                        state        <= RECV;
                    end else if (start) begin
                        err <= 1'b1;
                    end
                end
                RECV: begin
                    if (bus.in_valid && bus.in_ready) begin
                        sr       <= {sr[15:0], bus.in_byte};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            bus.in_ready <= 1'b0;
                            bus.mem_we   <= 1'b1;
                            bus.mem_addr <= 32'({word_index, 2'b00});
                            bus.mem_wd   <= {sr, bus.in_byte};
                            state        <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (word_index == count - CW'(1)) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        cpu_rst_n <= 1'b1;
                        state     <= DONE;
                    end else begin
                        word_index   <= word_index + CW'(1);
                        byte_cnt     <= '0;
                        bus.in_ready <= 1'b1;
                        state        <= RECV;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed checks of the instruction-memory loader.
module tb_imem_loader;
    localparam int DEPTH = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] word_count = '0;
    logic          busy, done, err, cpu_rst_n;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            c0;
    logic [31:0]   wa[$];
    logic [31:0]   wd[$];
    int            wcy[$];

    imem_loader_if bus ();

    imem_loader #(.DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .word_count(word_count),
        .bus(bus.master),
        .busy(busy),
        .done(done),
        .err(err),
        .cpu_rst_n(cpu_rst_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wa.push_back(bus.mem_addr);
            wd.push_back(bus.mem_wd);
            wcy.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wcy.delete();
    endtask

    task automatic do_start(input int n);
        start = 1'b1;
        word_count = CW'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_byte = b;
        for (int i = 0; i < 20 && !bus.in_ready; i++) @(negedge clk);
        if (!bus.in_ready) check("ready_timeout", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        send(w[31:24]);
        send(w[23:16]);
        send(w[15:8]);
        send(w[7:0]);
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 20 && !done; i++) @(negedge clk);
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ctl"}, 32'({bus.in_ready, bus.mem_we, busy, done, err, cpu_rst_n}), 32'd0);
        check({tag, "_addr"}, bus.mem_addr, 32'd0);
        check({tag, "_wd"}, bus.mem_wd, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_byte = 8'h00;
        @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ctl", 32'({busy, done, cpu_rst_n}), 32'd0);

        // basic two-word load with in_valid held high
        clear_log();
        do_start(2);
        c0 = cyc;
        check("basic_busy", 32'({busy, bus.in_ready}), 32'b11);
        send_word(32'h20020005);
        send_word(32'h2003000C);
        bus.in_valid = 1'b0;
        check("basic_done_early", 32'(done), 32'd0);
        @(negedge clk);
        check("basic_done_cyc", 32'(cyc - c0), 32'd10);
        check("basic_done", 32'({done, cpu_rst_n, busy, bus.in_ready}), 32'b1100);
        check("basic_nwrites", 32'(wa.size()), 32'd2);
        if (wa.size() == 2) begin
            check("basic_a0", wa[0], 32'h0);
            check("basic_d0", wd[0], 32'h20020005);
            check("basic_a1", wa[1], 32'h4);
            check("basic_d1", wd[1], 32'h2003000C);
            check("basic_lat", 32'(wcy[0] - c0), 32'd4);
            check("basic_gap", 32'(wcy[1] - wcy[0]), 32'd5);
        end

        // gaps in in_valid, started from DONE
        clear_log();
        do_start(1);
        check("reload_clear", 32'({done, cpu_rst_n, busy}), 32'b001);
        send(8'hAC);
        send(8'h02);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("bp_stall", 32'({bus.in_ready, bus.mem_we}), 32'b10);
        send(8'h00);
        send(8'h54);
        bus.in_valid = 1'b0;
        check("bp_write", 32'({bus.in_ready, bus.mem_we}), 32'b01);
        @(negedge clk);
        check("bp_done", 32'({done, bus.mem_we}), 32'b10);
        repeat (3) @(negedge clk);
        check("bp_nwrites", 32'(wa.size()), 32'd1);
        if (wa.size() == 1) begin
            check("bp_a0", wa[0], 32'h0);
            check("bp_d0", wd[0], 32'hAC020054);
        end
        do_start(0);
        check("done_reject", 32'({err, done, cpu_rst_n, busy}), 32'b1110);

        // rejected counts from IDLE
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_log();
        do_start(0);
        check("rej0", 32'({err, busy, bus.in_ready, cpu_rst_n}), 32'b1000);
        do_start(DEPTH + 1);
        check("rej_big", 32'({err, busy, bus.in_ready, cpu_rst_n}), 32'b1000);
        bus.in_valid = 1'b1;
        bus.in_byte = 8'h5A;
        repeat (5) @(negedge clk);
        bus.in_valid = 1'b0;
        check("rej_nowrite", 32'(wa.size()), 32'd0);
        check("rej_idle", 32'({busy, done}), 32'd0);
        do_start(1);
        check("rej_recover", 32'({err, busy}), 32'b01);
        send_word(32'hDEADBEEF);
        bus.in_valid = 1'b0;
        wait_done("rej_done");
        @(negedge clk);
        check("rej_d0", (wd.size() == 1) ? wd[0] : 32'hFFFF_FFFF, 32'hDEADBEEF);

        // full-depth load
        clear_log();
        do_start(DEPTH);
        for (int i = 0; i < DEPTH; i++) send_word(32'h1000_0000 + 32'(i));
        bus.in_valid = 1'b0;
        wait_done("full_done");
        @(negedge clk);
        check("full_nwrites", 32'(wa.size()), 32'(DEPTH));
        for (int i = 0; i < DEPTH && i < wa.size(); i++) begin
            check($sformatf("full_a%0d", i), wa[i], 32'(4 * i));
            check($sformatf("full_d%0d", i), wd[i], 32'h1000_0000 + 32'(i));
        end

        // reset after one and a half words
        clear_log();
        do_start(2);
        send_word(32'h11111111);
        send(8'h22);
        send(8'h22);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_vals("midrst_now");
        @(negedge clk);
        check_reset_vals("midrst_hold");
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_after", 32'({bus.in_ready, busy, cpu_rst_n}), 32'd0);
        do_start(1);
        send_word(32'h33333333);
        bus.in_valid = 1'b0;
        wait_done("midrst_done");
        @(negedge clk);
        check("midrst_nwrites", 32'(wa.size()), 32'd2);
        if (wa.size() == 2) begin
            check("midrst_a", wa[1], 32'h0);
            check("midrst_d", wd[1], 32'h33333333);
        end

        // start during RECV is ignored
        clear_log();
        do_start(2);
        send(8'hAA);
        send(8'hBB);
        bus.in_valid = 1'b0;
        do_start(1);
        check("busy_ign", 32'({busy, err, bus.in_ready}), 32'b101);
        send(8'hCC);
        send(8'hDD);
        send_word(32'h01020304);
        bus.in_valid = 1'b0;
        wait_done("busy_done");
        @(negedge clk);
        check("busy_nwrites", 32'(wa.size()), 32'd2);
        if (wa.size() == 2) begin
            check("busy_d0", wd[0], 32'hAABBCCDD);
            check("busy_a1", wa[1], 32'h4);
            check("busy_d1", wd[1], 32'h01020304);
        end

        // reload after DONE
        clear_log();
        do_start(1);
        check("reload2_clear", 32'({done, cpu_rst_n, busy}), 32'b001);
        send_word(32'hCAFEF00D);
        bus.in_valid = 1'b0;
        wait_done("reload2_done");
        check("reload2_cpu", 32'(cpu_rst_n), 32'd1);
        @(negedge clk);
        check("reload2_nwrites", 32'(wa.size()), 32'd1);
        if (wa.size() == 1) begin
            check("reload2_a", wa[0], 32'h0);
            check("reload2_d", wd[0], 32'hCAFEF00D);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that fills the single-cycle MIPS core's instruction memory from a byte stream before execution. It accepts bytes over a valid/ready handshake and assembles them big-endian into 32-bit instructions. Each instruction is written through a word write port, at byte address 4·n, so the fetch path's word index A[31:2] addresses it. The core is held in reset until the requested number of words has been written.

## Interface
Parameters:
- DEPTH, 32: instruction memory size in words.
- CW, $clog2(DEPTH)+1: width of the word-count input.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a load; sampled only in IDLE or DONE.
- word_count  in  CW  number of words to load; sampled on the accepted start.
- in_valid  in  1  in_byte is valid.
- in_byte  in  8  program byte, most significant byte of each word first.
- in_ready  out  1  loader accepts in_byte this cycle.
- mem_we  out  1  instruction-memory write strobe, one cycle per word.
- mem_addr  out  32  byte address of the write: 4·word_index, bits [1:0] = 0.
- mem_wd  out  32  assembled instruction.
- busy  out  1  load in progress.
- done  out  1  load completed; held until the next accepted start or reset.
- err  out  1  last start was rejected; sticky until the next start or reset.
- cpu_rst_n  out  1  core reset; low except in DONE.

## Operation
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - Start with word_count in 1..DEPTH: latch the count, clear word_index and byte_cnt, clear err, go to RECV.
  - Start with word_count 0 or > DEPTH: set err, stay in IDLE, perform no write.
- RECV:
  - in_ready = 1. A byte transfers when in_valid && in_ready.
  - Byte k (0..3) of the word goes to shift register bits [31-8k : 24-8k].
  - On the 4th transfer, go to WRITE.
- WRITE:
  - in_ready = 0. mem_we = 1, mem_addr = {word_index, 2'b00} zero-extended, mem_wd = assembled word. This lasts one cycle.
  - If word_index == count-1, go to DONE. Otherwise increment word_index, clear byte_cnt, go to RECV.
- DONE:
  - done = 1, cpu_rst_n = 1, in_ready = 0.
  - Start is handled exactly as in IDLE. A valid start clears done and drives cpu_rst_n low in the next cycle. A rejected start sets err and stays in DONE with cpu_rst_n = 1.
- busy = 1 in RECV and WRITE. Start during busy is ignored, with no effect on err.
- Bytes presented while in_ready = 0 are not consumed. Any bytes remaining after the final word stay unconsumed.
- mem_addr and mem_wd hold their last values when mem_we = 0. Only mem_we qualifies them.

## Timing
- Reset values (asynchronous, immediate):
  - State = IDLE.
  - in_ready, mem_we, busy, done, err = 0.
  - mem_addr = 0, mem_wd = 0.
  - cpu_rst_n = 0.
  - Internal counters and the shift register = 0.
- Reset asserted mid-load aborts the load. Words already written are not rolled back. The loader returns to IDLE and the core stays in reset.
- Start accepted at edge t: busy = 1 and in_ready = 1 from cycle t+1.
- mem_we pulses in the cycle after the 4th byte of each word is accepted.
- Best-case throughput is 5 cycles per word: 4 byte transfers plus 1 WRITE cycle. A load of N words with in_valid held high takes 5N cycles from the first byte.
- DONE is entered on the edge ending the final WRITE cycle. done = 1 and cpu_rst_n = 1 in the next cycle.
- in_valid gaps stall byte_cnt; no timeout.
- word_index never exceeds DEPTH-1. The last word of a DEPTH-word load is written at address 4·(DEPTH-1).

## Test plan
- Basic load: start with word_count=2, then bytes 20 02 00 05 20 03 00 0C streamed with in_valid held high. Required: two mem_we pulses, (0x0, 0x20020005) then (0x4, 0x2003000C), 5 cycles apart; done = 1 and cpu_rst_n = 1 ten cycles after the first byte.
- Backpressure and gaps: load 1 word 0xAC020054 with in_valid dropped for 3 cycles between bytes 2 and 3. Required: single write of 0xAC020054 at 0x0; no extra mem_we; in_ready = 0 during WRITE.
- Rejected counts: start with word_count=0, then with word_count=DEPTH+1. Required: err = 1, state stays IDLE, no mem_we, cpu_rst_n = 0. A following valid start clears err.
- Full depth: load DEPTH words with word i = 0x1000_0000+i. Required: the last write is at 4·(DEPTH-1); no write at 4·DEPTH; done asserts.
- Reset mid-load: drop rst_n after 1.5 words. Required: all outputs return to their reset values immediately and stay there; in_ready = 0 afterward; a new start reloads from address 0.
- Start ignored when busy, and reload: pulse start during RECV, which must be ignored. After DONE, start with word_count=1. Required: done clears and cpu_rst_n = 0 the cycle after the start; the new word is written at 0x0; DONE is re-entered.
